// File: rtl/soc_memory_pkg.sv
// Shared constants and address decode for the unified memory and GPIO block.
package soc_memory_pkg;

  localparam logic [2:0] WE_NONE = 3'b000;
  localparam logic [2:0] WE_WORD = 3'b001;
  localparam logic [2:0] WE_HALF = 3'b010;
  localparam logic [2:0] WE_BYTE = 3'b100;

  localparam logic [31:0] GPIO_OUT_OFS = 32'h0000_0000;
  localparam logic [31:0] GPIO_DIR_OFS = 32'h0000_0004;
  localparam logic [31:0] GPIO_IN_OFS  = 32'h0000_0008;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Bit 31 selects the IO region.
  function automatic logic is_io(input logic [31:0] a);
    return (a & 32'h8000_0000) != 32'h0;
  endfunction

endpackage

// File: rtl/soc_memory_gpio_port.sv
// GPIO output/direction registers, tristate pin drive and 2-flop input synchronizer.
module gpio_port #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             out_we_i,
  input  logic             dir_we_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] out_o,
  output logic [Width-1:0] dir_o,
  output logic [Width-1:0] in_o,
  inout  wire  [Width-1:0] gpio_io
);

  logic [Width-1:0] out_q, dir_q, sync1_q, sync2_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q   <= '0;
      dir_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      if (out_we_i) out_q <= wdata_i;
      if (dir_we_i) dir_q <= wdata_i;
      sync1_q <= gpio_io;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < Width; i++) begin : g_pin
    assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

  assign out_o = out_q;
  assign dir_o = dir_q;
  assign in_o  = sync2_q;

endmodule

// File: rtl/soc_memory.sv
// Unified instruction/data RAM with async fetch port, registered load port and GPIO IO region.
module soc_memory
  import soc_memory_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned GPIO_WIDTH = 8,
  parameter logic [31:0] GPIO_BASE  = 32'h8000_0000,
  parameter string       INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           iaddr,
  output logic [31:0]           inst,
  input  logic [2:0]            write_enable,
  input  logic [31:0]           addr,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  inout  wire  [GPIO_WIDTH-1:0] gpio
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0] mem_q [MEM_WORDS];

  logic [AW-1:0]         d_idx, i_idx;
  logic                  d_io;
  logic [31:0]           io_ofs;
  logic [3:0]            be;
  logic [31:0]           wdata;
  logic                  io_we, out_we, dir_we;
  logic [GPIO_WIDTH-1:0] gpio_out, gpio_dir, gpio_in;
  logic [31:0]           data_out_d, data_out_q;

  assign d_idx  = addr[AW+1:2];
  assign i_idx  = iaddr[AW+1:2];
  assign d_io   = is_io(addr);
  assign io_ofs = addr - GPIO_BASE;

  assign inst = is_io(iaddr) ? NOP_INST : mem_q[i_idx];

  // Lane enables; a store coinciding with reset is dropped.
  always_comb begin
    be    = 4'b0000;
    wdata = data_in;
    if (!d_io && !rst) begin
      case (write_enable)
        WE_BYTE: begin
          be    = 4'b0001 << addr[1:0];
          wdata = {4{data_in[7:0]}};
        end
        WE_HALF: begin
          be    = addr[1] ? 4'b1100 : 4'b0011;
          wdata = {2{data_in[15:0]}};
        end
        WE_WORD: be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be[b]) mem_q[d_idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign io_we  = d_io && (write_enable != WE_NONE);
  assign out_we = io_we && (io_ofs == GPIO_OUT_OFS);
  assign dir_we = io_we && (io_ofs == GPIO_DIR_OFS);

  gpio_port #(
    .Width(GPIO_WIDTH)
  ) u_gpio (
    .clk_i   (clk),
    .rst_i   (rst),
    .out_we_i(out_we),
    .dir_we_i(dir_we),
    .wdata_i (data_in[GPIO_WIDTH-1:0]),
    .out_o   (gpio_out),
    .dir_o   (gpio_dir),
    .in_o    (gpio_in),
    .gpio_io (gpio)
  );

  always_comb begin
    data_out_d = '0;
    if (d_io) begin
      if (io_ofs == GPIO_OUT_OFS)      data_out_d = 32'(gpio_out);
      else if (io_ofs == GPIO_DIR_OFS) data_out_d = 32'(gpio_dir);
      else if (io_ofs == GPIO_IN_OFS)  data_out_d = 32'(gpio_in);
    end else begin
      data_out_d = mem_q[d_idx] >> {addr[1:0], 3'b000};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_out_q <= '0;
    else     data_out_q <= data_out_d;
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_soc_memory.sv
// Self-checking bench for soc_memory: vector table plus reset and GPIO-input sequences.
module tb_soc_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr;
  logic [31:0] inst;
  logic [2:0]  write_enable;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  wire  [7:0]  gpio;
  logic        pin_en;
  logic [7:0]  pin_drv;

  assign gpio = pin_en ? pin_drv : 8'hzz;

  soc_memory dut (
    .clk         (clk),
    .rst         (rst),
    .iaddr       (iaddr),
    .inst        (inst),
    .write_enable(write_enable),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .gpio        (gpio)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  we;
    logic [31:0] a;
    logic [31:0] din;
    logic [31:0] ia;
    bit          chk_d;
    logic [31:0] exp_d;
    bit          chk_i;
    logic [31:0] exp_i;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(string n, logic [2:0] we, logic [31:0] a, logic [31:0] din,
                              logic [31:0] ia, bit cd, logic [31:0] ed, bit ci,
                              logic [31:0] ei);
    vec_t v;
    v.name = n; v.we = we; v.a = a; v.din = din; v.ia = ia;
    v.chk_d = cd; v.exp_d = ed; v.chk_i = ci; v.exp_i = ei;
    return v;
  endfunction

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %08h expected %08h", n, act, exp);
  endtask

  task automatic push(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // One clock: the load launched before the edge is visible right after it.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(e.name, data_out, e.val);
    end
  endtask

  initial begin
    rst = 1'b1; iaddr = 32'h8000_0000; write_enable = 3'b000; addr = 32'h0;
    data_in = 32'h0; pin_en = 1'b0; pin_drv = 8'h00;

    vecs.push_back(mk("st_word",   3'b001, 32'h10,   32'hDEADBEEF, 32'h10,   0, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk("ld_word",   3'b000, 32'h10,   32'h0,        32'h10,   1, 32'hDEADBEEF, 1, 32'hDEADBEEF));
    vecs.push_back(mk("st_base",   3'b001, 32'h10,   32'h11223344, 32'h10,   1, 32'hDEADBEEF, 1, 32'h11223344));
    vecs.push_back(mk("st_byte",   3'b100, 32'h11,   32'hFFFFFFAA, 32'h10,   1, 32'h00112233, 1, 32'h1122AA44));
    vecs.push_back(mk("ld_byte",   3'b000, 32'h11,   32'h0,        32'h10,   1, 32'h001122AA, 1, 32'h1122AA44));
    vecs.push_back(mk("st_base2",  3'b001, 32'h14,   32'h11223344, 32'h14,   0, 0, 1, 32'h11223344));
    vecs.push_back(mk("st_half",   3'b010, 32'h17,   32'hFFFFBEEF, 32'h14,   1, 32'h00000011, 1, 32'hBEEF3344));
    vecs.push_back(mk("we_011",    3'b011, 32'h16,   32'h12345678, 32'h14,   1, 32'h0000BEEF, 1, 32'hBEEF3344));
    vecs.push_back(mk("we_111",    3'b111, 32'h14,   32'h0,        32'h14,   1, 32'hBEEF3344, 1, 32'hBEEF3344));
    vecs.push_back(mk("st_cafe",   3'b001, 32'h20,   32'hCAFEF00D, 32'h20,   0, 0, 1, 32'hCAFEF00D));
    vecs.push_back(mk("rbw",       3'b001, 32'h20,   32'h00000055, 32'h20,   1, 32'hCAFEF00D, 1, 32'h00000055));
    vecs.push_back(mk("rbw_next",  3'b000, 32'h20,   32'h0,        32'h20,   1, 32'h00000055, 1, 32'h00000055));
    vecs.push_back(mk("wrap_ld",   3'b000, 32'h1010, 32'h0,        32'h1014, 1, 32'h1122AA44, 1, 32'hBEEF3344));
    vecs.push_back(mk("ld_top",    3'b000, 32'h13,   32'h0,        32'h8000_0000, 1, 32'h00000011, 1, 32'h00000013));
    vecs.push_back(mk("wrap_st",   3'b001, 32'h1020, 32'h00000077, 32'h8000_0010, 1, 32'h00000055, 1, 32'h00000013));
    vecs.push_back(mk("wrap_chk",  3'b000, 32'h20,   32'h0,        32'h20,   1, 32'h00000077, 1, 32'h00000077));
    vecs.push_back(mk("st_30",     3'b001, 32'h30,   32'h12345678, 32'h30,   0, 0, 1, 32'h12345678));
    vecs.push_back(mk("io_dir_st", 3'b001, 32'h8000_0004, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 0, 0));
    vecs.push_back(mk("io_out_st", 3'b010, 32'h8000_0000, 32'h1234005A, 32'h0, 1, 32'h0, 0, 0));
    vecs.push_back(mk("io_out_ld", 3'b000, 32'h8000_0000, 32'h0, 32'h0, 1, 32'h0000005A, 0, 0));
    vecs.push_back(mk("io_dir_ld", 3'b000, 32'h8000_0004, 32'h0, 32'h0, 1, 32'h000000FF, 0, 0));
    vecs.push_back(mk("io_bad_st", 3'b001, 32'h8000_000C, 32'hFF, 32'h0, 1, 32'h0, 0, 0));
    vecs.push_back(mk("io_bad_ld", 3'b000, 32'h8000_000C, 32'h0, 32'h0, 1, 32'h0, 0, 0));
    vecs.push_back(mk("io_in_out", 3'b000, 32'h8000_0008, 32'h0, 32'h0, 1, 32'h0000005A, 0, 0));
    vecs.push_back(mk("io_hi_ld",  3'b000, 32'h8000_0010, 32'h0, 32'h0, 1, 32'h0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 32'h0);
    check("reset_nop", inst, 32'h0000_0013);
    rst = 1'b0;

    foreach (vecs[k]) begin
      write_enable = vecs[k].we;
      addr         = vecs[k].a;
      data_in      = vecs[k].din;
      iaddr        = vecs[k].ia;
      if (vecs[k].chk_d) push(vecs[k].name, vecs[k].exp_d);
      step();
      if (vecs[k].chk_i) check({vecs[k].name, "_inst"}, inst, vecs[k].exp_i);
    end
    write_enable = 3'b000;
    check("gpio_drive", {24'h0, gpio}, 32'h0000005A);

    // Reset mid-run with a pending store to 0x30 that must be dropped.
    rst = 1'b1; write_enable = 3'b001; addr = 32'h30; data_in = 32'h99;
    #1;
    check("rst_async_data_out", data_out, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; write_enable = 3'b000; addr = 32'h8000_0000;
    push("rst_out_cleared", 32'h0);
    step();
    addr = 32'h8000_0004;
    push("rst_dir_cleared", 32'h0);
    step();
    addr = 32'h30;
    push("rst_write_dropped", 32'h12345678);
    step();

    // Input synchronizer latency: 3 edges from pin change to data_out.
    pin_en = 1'b1; pin_drv = 8'h00; addr = 32'h8000_0008;
    repeat (3) step();
    pin_drv = 8'h3C;
    push("gpio_in_edge1", 32'h0);
    step();
    check("gpio_pin_level", {24'h0, gpio}, 32'h0000003C);
    push("gpio_in_edge2", 32'h0);
    step();
    push("gpio_in_edge3", 32'h0000003C);
    step();

    if (exp_q.size() != 0) check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
